seg7_display_ctrl: RTL and testbench

- Registered, parametrised seven-segment display controller for the HEX0..HEXn bank. Replaces purely combinational digit-to-segment wiring.
- Per-digit hex decode over NUM_DIGITS digits, with a load-strobe data latch, per-digit blinking from an internal divider, and global display enable.
- Sits between the counter/stopwatch datapath and the board HEX pins; all segment outputs are registered.

---
 rtl/seg7_display_ctrl.sv | 152 +++++++++++++++
 tb/tb_seg7_display_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_display_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_display_ctrl
//
// Registered seven-segment controller for a bank of NUM_DIGITS hex digits.
// Digits are captured by a load strobe, decoded to active-low segment
// patterns and driven out of a register, so the HEX pins never see
// combinational glitches. Each digit can blink from a shared divider, and
// the whole bank can be blanked with disp_en.
//
// Ports:
//   clk          system clock, rising-edge active
//   rst_n        synchronous active-low reset
//   data         packed digits, digit i = data[4i+3:4i]
//   load         latch data into the digit register
//   blink_mask   bit i = 1 makes digit i blink
//   blink_sync   restart the blink divider in the visible phase
//   disp_en      0 blanks every digit (the divider keeps running)
//   seg          active-low segments, group i = seg[7i+6:7i], bit 6 = g
//   blink_phase  1 while blinking digits are blanked
//
// Optional feature:
//   SEG7_LZ_BLANK_EN  when defined, leading zeros are blanked (digit 0 is
//                     always shown). When undefined no such logic exists.
// ---------------------------------------------------------------------------
module seg7_display_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    blink_sync,
    input  logic                    disp_en,
    output logic [7*NUM_DIGITS-1:0] seg,
    output logic                    blink_phase
);

    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    logic [4*NUM_DIGITS-1:0] data_q;
    logic [NUM_DIGITS-1:0]   mask_q;
    logic                    en_q;
    logic [CNT_W-1:0]        cnt;
    logic [7*NUM_DIGITS-1:0] seg_next;

    // Active-low hex decode, bit order g..a.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'h0: pattern = 7'h40;
            4'h1: pattern = 7'h79;
            4'h2: pattern = 7'h24;
            4'h3: pattern = 7'h30;
            4'h4: pattern = 7'h19;
            4'h5: pattern = 7'h12;
            4'h6: pattern = 7'h02;
            4'h7: pattern = 7'h78;
            4'h8: pattern = 7'h00;
            4'h9: pattern = 7'h10;
            4'hA: pattern = 7'h08;
            4'hB: pattern = 7'h03;
            4'hC: pattern = 7'h46;
            4'hD: pattern = 7'h21;
            4'hE: pattern = 7'h06;
            default: pattern = 7'h0E;
        endcase
        return pattern;
    endfunction

    // Input latch stage. Mask and enable are resampled every cycle so that
    // they share the same two-cycle latency to seg as a loaded digit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
            mask_q <= '0;
            en_q   <= 1'b0;
        end else begin
            if (load) begin
                data_q <= data;
            end
            mask_q <= blink_mask;
            en_q   <= disp_en;
        end
    end

    // Blink divider. blink_sync wins over a wrap in the same cycle so the
    // caller always lands in the visible phase with a full half-period ahead.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            blink_phase <= 1'b0;
        end else if (blink_sync) begin
            cnt         <= '0;
            blink_phase <= 1'b0;
        end else if (cnt == CNT_LAST) begin
            cnt         <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

`ifdef SEG7_LZ_BLANK_EN
    logic [NUM_DIGITS-1:0] lz_blank;

    // A digit is zero-blanked only while every digit above it is also a
    // blanked zero; the run stops at the first non-zero digit. Digit 0 is
    // never part of the run so a value of zero still shows a single "0".
    always_comb begin
        logic run;
        lz_blank = '0;
        run      = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            run         = run && (data_q[4*i +: 4] == 4'h0);
            lz_blank[i] = run;
        end
    end
`endif

    // Per-digit blanking priority: global enable, then blink, then
    // leading-zero suppression, otherwise the decoded digit.
    always_comb begin
        seg_next = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!en_q) begin
                seg_next[7*i +: 7] = SEG_BLANK;
            end else if (mask_q[i] && blink_phase) begin
                seg_next[7*i +: 7] = SEG_BLANK;
`ifdef SEG7_LZ_BLANK_EN
            end else if (lz_blank[i]) begin
                seg_next[7*i +: 7] = SEG_BLANK;
`endif
            end else begin
                seg_next[7*i +: 7] = hex_to_seg(data_q[4*i +: 4]);
            end
        end
    end

    // Output register; reset shows a fully blank display.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg <= {NUM_DIGITS{SEG_BLANK}};
        end else begin
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg7_display_ctrl
//
// Directed testbench for seg7_display_ctrl with six digits and a short blink
// divider (BLINK_DIV = 4). Expected segment patterns are hand-decoded
// constants; leading-zero variants are selected with SEG7_LZ_BLANK_EN.
// ---------------------------------------------------------------------------
module tb_seg7_display_ctrl;

    localparam int NUM_DIGITS = 6;
    localparam int BLINK_DIV  = 4;

    logic        clk;
    logic        rst_n;
    logic [23:0] data;
    logic        load;
    logic [5:0]  blink_mask;
    logic        blink_sync;
    logic        disp_en;
    logic [41:0] seg;
    logic        blink_phase;

    int vector_count;
    int miscompare_count;

    localparam logic [41:0] BLANK_ALL = {6{7'h7F}};
`ifdef SEG7_LZ_BLANK_EN
    localparam logic [34:0] UPPER_ZERO = {5{7'h7F}};
    localparam logic [41:0] EXP_LOAD1  = {7'h7F, 7'h7F, 7'h79, 7'h24, 7'h08, 7'h0E};
    localparam logic [41:0] EXP_C      = {7'h7F, 7'h79, 7'h30, 7'h12, 7'h78, 7'h10};
`else
    localparam logic [34:0] UPPER_ZERO = {5{7'h40}};
    localparam logic [41:0] EXP_LOAD1  = {7'h40, 7'h40, 7'h79, 7'h24, 7'h08, 7'h0E};
    localparam logic [41:0] EXP_C      = {7'h40, 7'h79, 7'h30, 7'h12, 7'h78, 7'h10};
`endif
    localparam logic [41:0] SEG_ZERO_ALL = {UPPER_ZERO, 7'h40};
    localparam logic [41:0] EXP_A        = {7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19};
    localparam logic [41:0] EXP_B        = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08};
    localparam logic [41:0] EXP_D        = {7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    localparam logic [41:0] BLINK_ON     = {UPPER_ZERO, 7'h00};
    localparam logic [41:0] BLINK_OFF    = {UPPER_ZERO, 7'h7F};

    seg7_display_ctrl #(
        .NUM_DIGITS(NUM_DIGITS),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data       (data),
        .load       (load),
        .blink_mask (blink_mask),
        .blink_sync (blink_sync),
        .disp_en    (disp_en),
        .seg        (seg),
        .blink_phase(blink_phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive every input at once, always 1 time unit after a rising edge.
    task automatic applyStimulus(input logic        rst_n_v,
                                 input logic        load_v,
                                 input logic [23:0] data_v,
                                 input logic [5:0]  mask_v,
                                 input logic        sync_v,
                                 input logic        en_v);
        rst_n      = rst_n_v;
        load       = load_v;
        data       = data_v;
        blink_mask = mask_v;
        blink_sync = sync_v;
        disp_en    = en_v;
    endtask

    // Advance n rising edges and settle just past the last one.
    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag,
                               input logic [41:0] observed,
                               input logic [41:0] expected);
        vector_count++;
        if (observed !== expected) begin
            miscompare_count++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        vector_count     = 0;
        miscompare_count = 0;
        applyStimulus(1'b0, 1'b1, 24'h123456, 6'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;

        // Reset held with load asserted: display blank, load ignored.
        waitCycles(3);
        checkOutput("reset_seg", seg, BLANK_ALL);
        checkOutput("reset_phase", {41'b0, blink_phase}, 42'd0);

        applyStimulus(1'b1, 1'b0, 24'h123456, 6'b0, 1'b0, 1'b1);
        waitCycles(2);
        checkOutput("post_reset_seg", seg, SEG_ZERO_ALL);

        // Single load: unchanged after one edge, new value after two.
        applyStimulus(1'b1, 1'b1, 24'h0012AF, 6'b0, 1'b0, 1'b1);
        waitCycles(1);
        applyStimulus(1'b1, 1'b0, 24'h0012AF, 6'b0, 1'b0, 1'b1);
        checkOutput("load_lat_1", seg, SEG_ZERO_ALL);
        waitCycles(1);
        checkOutput("load_lat_2", seg, EXP_LOAD1);

        // Load held high across three back-to-back values.
        applyStimulus(1'b1, 1'b1, 24'h987654, 6'b0, 1'b0, 1'b1);
        waitCycles(1);
        applyStimulus(1'b1, 1'b1, 24'hFEDCBA, 6'b0, 1'b0, 1'b1);
        waitCycles(1);
        checkOutput("b2b_a", seg, EXP_A);
        applyStimulus(1'b1, 1'b1, 24'h013579, 6'b0, 1'b0, 1'b1);
        waitCycles(1);
        checkOutput("b2b_b", seg, EXP_B);
        applyStimulus(1'b1, 1'b0, 24'h013579, 6'b0, 1'b0, 1'b1);
        waitCycles(1);
        checkOutput("b2b_c", seg, EXP_C);

        applyStimulus(1'b1, 1'b1, 24'h100000, 6'b0, 1'b0, 1'b1);
        waitCycles(1);
        applyStimulus(1'b1, 1'b0, 24'h100000, 6'b0, 1'b0, 1'b1);
        waitCycles(1);
        checkOutput("top_digit_set", seg, EXP_D);

        // Blink digit 0 showing 8; sync aligns the divider at edge e0.
        applyStimulus(1'b1, 1'b1, 24'h000008, 6'b0, 1'b0, 1'b1);
        waitCycles(1);
        applyStimulus(1'b1, 1'b0, 24'h000008, 6'b000001, 1'b1, 1'b1);
        waitCycles(1);
        applyStimulus(1'b1, 1'b0, 24'h000008, 6'b000001, 1'b0, 1'b1);
        for (int t = 1; t <= 12; t++) begin
            waitCycles(1);
            checkOutput($sformatf("blink_phase_e%0d", t), {41'b0, blink_phase},
                        42'(((t / 4) % 2)));
            checkOutput($sformatf("blink_seg_e%0d", t), seg,
                        (((t - 1) / 4) % 2 == 1) ? BLINK_OFF : BLINK_ON);
        end

        // Run to e19 (cnt = 3, phase 0) and sync on the wrap edge.
        waitCycles(7);
        checkOutput("pre_sync_phase", {41'b0, blink_phase}, 42'd0);
        applyStimulus(1'b1, 1'b0, 24'h000008, 6'b000001, 1'b1, 1'b1);
        waitCycles(1);
        checkOutput("sync_wrap_phase", {41'b0, blink_phase}, 42'd0);
        applyStimulus(1'b1, 1'b0, 24'h000008, 6'b000001, 1'b0, 1'b1);
        waitCycles(3);
        checkOutput("sync_hold_phase", {41'b0, blink_phase}, 42'd0);
        waitCycles(1);
        checkOutput("sync_next_toggle", {41'b0, blink_phase}, 42'd1);

        // Display disable while blinking; divider keeps running.
        applyStimulus(1'b1, 1'b0, 24'h000008, 6'b000001, 1'b0, 1'b0);
        waitCycles(1);
        checkOutput("dis_lat_1", seg, BLINK_OFF);
        waitCycles(1);
        checkOutput("dis_blank", seg, BLANK_ALL);
        waitCycles(2);
        checkOutput("dis_phase_runs", {41'b0, blink_phase}, 42'd0);
        applyStimulus(1'b1, 1'b0, 24'h000008, 6'b000001, 1'b0, 1'b1);
        waitCycles(1);
        checkOutput("en_lat_1", seg, BLANK_ALL);
        waitCycles(1);
        checkOutput("en_resume", seg, BLINK_ON);

        // Reset in the blanked phase restarts the divider and clears data.
        waitCycles(2);
        checkOutput("mid_blink_phase", {41'b0, blink_phase}, 42'd1);
        waitCycles(1);
        applyStimulus(1'b0, 1'b1, 24'hFFFFFF, 6'b0, 1'b0, 1'b1);
        waitCycles(1);
        checkOutput("rst2_phase", {41'b0, blink_phase}, 42'd0);
        checkOutput("rst2_seg", seg, BLANK_ALL);
        applyStimulus(1'b1, 1'b0, 24'hFFFFFF, 6'b0, 1'b0, 1'b1);
        waitCycles(2);
        checkOutput("rst2_data_cleared", seg, SEG_ZERO_ALL);
        checkOutput("rst2_phase_cnt2", {41'b0, blink_phase}, 42'd0);
        waitCycles(1);
        checkOutput("rst2_phase_cnt3", {41'b0, blink_phase}, 42'd0);
        waitCycles(1);
        checkOutput("rst2_first_toggle", {41'b0, blink_phase}, 42'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
        $finish;
    end

endmodule
